// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, ID-resolved
// branch operand hazards and HI/LO accesses behind the multi-cycle mult/div unit.
module hazard_unit #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] RS_ID,
   input  logic [4:0] RT_ID,
   input  logic       UsesRT_ID,
   input  logic       Branch_ID,
   input  logic       BranchTaken_ID,
   input  logic       HiLoAcc_ID,
   input  logic       MemRead_EX,
   input  logic       RegWrite_EX,
   input  logic [4:0] wrReg_EX,
   input  logic       MemRead_MEM,
   input  logic [4:0] wrReg_MEM,
   input  logic       MulDiv_start_EX,
   input  logic       MulDiv_isDiv_EX,
   output logic       Stall_PC,
   output logic       Stall_IF_ID,
   output logic       Flush_ID_EX,
   output logic       Flush_IF_ID,
   output logic       MulDiv_busy,
   output logic       MulDiv_done
);

   localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   logic w_match_ex;
   logic w_match_mem;
   logic w_busy;
   logic w_load_use;
   logic w_br_ex;
   logic w_br_mem;
   logic w_hilo;
   logic w_stall;

   // Register 0 is hardwired, so it never creates a dependency.
   assign w_match_ex  = (wrReg_EX != 5'd0) &&
                        ((wrReg_EX == RS_ID) || (UsesRT_ID && (wrReg_EX == RT_ID)));
   assign w_match_mem = (wrReg_MEM != 5'd0) &&
                        ((wrReg_MEM == RS_ID) || (UsesRT_ID && (wrReg_MEM == RT_ID)));

   assign w_busy     = (r_state == S_BUSY);
   assign w_load_use = MemRead_EX & w_match_ex;
   assign w_br_ex    = Branch_ID & RegWrite_EX & w_match_ex;
   assign w_br_mem   = Branch_ID & MemRead_MEM & w_match_mem;
   assign w_hilo     = HiLoAcc_ID & (w_busy | MulDiv_start_EX);
   assign w_stall    = w_load_use | w_br_ex | w_br_mem | w_hilo;

   // A stalled branch never redirects; everything is forced low during reset.
   always_comb begin
      Stall_PC    = 1'b0;
      Stall_IF_ID = 1'b0;
      Flush_ID_EX = 1'b0;
      Flush_IF_ID = 1'b0;
      MulDiv_busy = 1'b0;
      MulDiv_done = 1'b0;
      if (!rst) begin
         Stall_PC    = w_stall;
         Stall_IF_ID = w_stall;
         Flush_ID_EX = w_stall;
         Flush_IF_ID = BranchTaken_ID & ~w_stall;
         MulDiv_busy = w_busy;
         MulDiv_done = w_busy && (r_cnt == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A start while busy is ignored: no restart, counter untouched.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (MulDiv_start_EX) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = MulDiv_isDiv_EX ? CNT_W'(DIV_CYCLES - 1)
                                             : CNT_W'(MUL_CYCLES - 1);
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random
// stimulus compared against a remaining-busy-cycles reference model.
module tb_hazard_unit;

   localparam int MUL_N = 4;
   localparam int DIV_N = 32;

   logic       clk;
   logic       rst;
   logic [4:0] RS_ID, RT_ID, wrReg_EX, wrReg_MEM;
   logic       UsesRT_ID, Branch_ID, BranchTaken_ID, HiLoAcc_ID;
   logic       MemRead_EX, RegWrite_EX, MemRead_MEM;
   logic       MulDiv_start_EX, MulDiv_isDiv_EX;
   logic       Stall_PC, Stall_IF_ID, Flush_ID_EX, Flush_IF_ID;
   logic       MulDiv_busy, MulDiv_done;

   int n_checks = 0;
   int n_errors = 0;
   int busy_left = 0;   // reference: busy cycles still to come (0 = idle)

   hazard_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst(rst),
      .RS_ID(RS_ID), .RT_ID(RT_ID), .UsesRT_ID(UsesRT_ID),
      .Branch_ID(Branch_ID), .BranchTaken_ID(BranchTaken_ID), .HiLoAcc_ID(HiLoAcc_ID),
      .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .wrReg_EX(wrReg_EX),
      .MemRead_MEM(MemRead_MEM), .wrReg_MEM(wrReg_MEM),
      .MulDiv_start_EX(MulDiv_start_EX), .MulDiv_isDiv_EX(MulDiv_isDiv_EX),
      .Stall_PC(Stall_PC), .Stall_IF_ID(Stall_IF_ID), .Flush_ID_EX(Flush_ID_EX),
      .Flush_IF_ID(Flush_IF_ID), .MulDiv_busy(MulDiv_busy), .MulDiv_done(MulDiv_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_dep(input int r);
      return (r != 0) && ((r == int'(RS_ID)) || (UsesRT_ID && (r == int'(RT_ID))));
   endfunction

   // Expected outputs straight from the hazard rules.
   task automatic check_model();
      bit stall, busy, done;
      if (rst) busy_left = 0;
      busy  = (busy_left > 0);
      done  = (busy_left == 1);
      stall = (MemRead_EX && ref_dep(int'(wrReg_EX)))
           || (Branch_ID && RegWrite_EX && ref_dep(int'(wrReg_EX)))
           || (Branch_ID && MemRead_MEM && ref_dep(int'(wrReg_MEM)))
           || (HiLoAcc_ID && (busy || MulDiv_start_EX));
      if (rst) begin
         stall = 0;
         busy  = 0;
         done  = 0;
      end
      check("Stall_PC",    int'(Stall_PC),    int'(stall));
      check("Stall_IF_ID", int'(Stall_IF_ID), int'(stall));
      check("Flush_ID_EX", int'(Flush_ID_EX), int'(stall));
      check("Flush_IF_ID", int'(Flush_IF_ID), int'(!rst && BranchTaken_ID && !stall));
      check("MulDiv_busy", int'(MulDiv_busy), int'(busy));
      check("MulDiv_done", int'(MulDiv_done), int'(done));
   endtask

   task automatic settle();
      #1;
      check_model();
   endtask

   // Clock edge, model update with the inputs seen at the edge, back to low phase.
   task automatic adv();
      @(posedge clk);
      if (rst)                busy_left = 0;
      else if (busy_left > 0) busy_left--;
      else if (MulDiv_start_EX) busy_left = MulDiv_isDiv_EX ? DIV_N : MUL_N;
      @(negedge clk);
   endtask

   task automatic clr();
      RS_ID = 0; RT_ID = 0; wrReg_EX = 0; wrReg_MEM = 0;
      UsesRT_ID = 0; Branch_ID = 0; BranchTaken_ID = 0; HiLoAcc_ID = 0;
      MemRead_EX = 0; RegWrite_EX = 0; MemRead_MEM = 0;
      MulDiv_start_EX = 0; MulDiv_isDiv_EX = 0;
   endtask

   initial begin
      logic [4:0] regs [4];
      regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10;

      clr();
      rst = 1'b1;
      MemRead_EX = 1; wrReg_EX = 8; RS_ID = 8; BranchTaken_ID = 1; HiLoAcc_ID = 1;
      @(negedge clk);
      settle();
      check("reset_stall", int'(Stall_PC), 0);
      adv();
      rst = 1'b0;
      clr();

      // Load-use, then r0, then RT not used.
      MemRead_EX = 1; wrReg_EX = 8; RS_ID = 8; settle();
      check("lu_stall", int'(Flush_ID_EX), 1);
      adv();
      wrReg_EX = 0; RS_ID = 0; settle();
      check("lu_r0", int'(Stall_PC), 0);
      adv();
      wrReg_EX = 8; RS_ID = 1; RT_ID = 8; UsesRT_ID = 0; settle();
      check("lu_rt_unused", int'(Stall_PC), 0);
      adv();
      clr();

      // Branch after ALU producer: one stall, then redirect.
      Branch_ID = 1; RegWrite_EX = 1; wrReg_EX = 9; RT_ID = 9; UsesRT_ID = 1;
      BranchTaken_ID = 1; settle();
      check("br_alu_stall", int'(Stall_PC), 1);
      check("br_alu_noflush", int'(Flush_IF_ID), 0);
      adv();
      RegWrite_EX = 0; wrReg_EX = 0; wrReg_MEM = 9; settle();
      check("br_alu_release", int'(Stall_PC), 0);
      check("br_alu_flush", int'(Flush_IF_ID), 1);
      adv();
      clr();

      // Branch after load: two stall cycles.
      Branch_ID = 1; RS_ID = 10; MemRead_EX = 1; RegWrite_EX = 1; wrReg_EX = 10; settle();
      check("br_ld_c1", int'(Stall_PC), 1);
      adv();
      MemRead_EX = 0; RegWrite_EX = 0; wrReg_EX = 0; MemRead_MEM = 1; wrReg_MEM = 10; settle();
      check("br_ld_c2", int'(Stall_PC), 1);
      adv();
      MemRead_MEM = 0; wrReg_MEM = 0; settle();
      check("br_ld_c3", int'(Stall_PC), 0);
      adv();
      clr();

      // Multiply with MFHI waiting in ID.
      MulDiv_start_EX = 1; HiLoAcc_ID = 1; settle();
      check("mul_start_stall", int'(Stall_PC), 1);
      adv();
      MulDiv_start_EX = 0;
      for (int i = 1; i <= MUL_N + 1; i++) begin
         settle();
         check("mul_busy", int'(MulDiv_busy), int'(i <= MUL_N));
         check("mul_done", int'(MulDiv_done), int'(i == MUL_N));
         check("mul_hilo_stall", int'(Stall_PC), int'(i <= MUL_N));
         adv();
      end
      clr();

      // Divide aborted by reset at busy cycle 10.
      MulDiv_start_EX = 1; MulDiv_isDiv_EX = 1; settle(); adv();
      clr();
      for (int i = 1; i < 10; i++) begin
         settle(); adv();
      end
      settle();
      check("div_busy_c10", int'(MulDiv_busy), 1);
      rst = 1'b1;
      #1;
      check("div_rst_async", int'(MulDiv_busy), 0);
      settle(); adv();
      rst = 1'b0;
      settle();
      check("div_after_rst", int'(MulDiv_busy), 0);
      MulDiv_start_EX = 1; settle(); adv();
      MulDiv_start_EX = 0;
      for (int i = 1; i <= MUL_N + 1; i++) begin
         settle();
         check("mul2_busy", int'(MulDiv_busy), int'(i <= MUL_N));
         adv();
      end

      // Illegal restart at busy cycle 2 is ignored.
      MulDiv_start_EX = 1; settle(); adv();
      MulDiv_start_EX = 0;
      for (int i = 1; i <= MUL_N + 1; i++) begin
         MulDiv_start_EX = (i == 2);
         MulDiv_isDiv_EX = (i == 2);
         settle();
         check("restart_busy", int'(MulDiv_busy), int'(i <= MUL_N));
         adv();
      end
      clr();

      // Random stimulus against the reference model.
      for (int n = 0; n < 3000; n++) begin
         RS_ID          = regs[$urandom_range(0, 3)];
         RT_ID          = regs[$urandom_range(0, 3)];
         wrReg_EX       = regs[$urandom_range(0, 3)];
         wrReg_MEM      = regs[$urandom_range(0, 3)];
         UsesRT_ID      = 1'($urandom_range(0, 1));
         Branch_ID      = 1'($urandom_range(0, 1));
         BranchTaken_ID = 1'($urandom_range(0, 1));
         HiLoAcc_ID     = 1'($urandom_range(0, 1));
         MemRead_EX     = 1'($urandom_range(0, 1));
         RegWrite_EX    = 1'($urandom_range(0, 1));
         MemRead_MEM    = 1'($urandom_range(0, 1));
         MulDiv_start_EX = ($urandom_range(0, 7) == 0);
         MulDiv_isDiv_EX = 1'($urandom_range(0, 1));
         rst            = ($urandom_range(0, 299) == 0);
         settle();
         adv();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
